// File: rtl/multitrack_looper.sv
// multitrack_looper: N-track loop recorder/mixer.
// Each sample_tick starts one frame. In track order, the frame reads every
// playing track (and the record track when overdubbing) from external RAM and
// writes the record track. It then mixes all playing tracks with the live
// sample and advances the loop position.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   sample_tick                      1-cycle frame start strobe
//   live_in                          signed live sample
//   rec_en/rec_track/overdub         record control (snapshotted per frame)
//   play_mask                        per-track playback enable (snapshotted)
//   loop_len                         loop length, 0 = 2**LEN_W
//   clear_pos                        restart loop at position 0
//   mem_req/we/addr/wdata/ack/rdata  req/ack RAM handshake
//   mix_out/mix_valid                saturated mix and its update pulse
//   pos/busy/overrun                 loop position, frame active, sticky tick overrun
module multitrack_looper #(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned LEN_W      = 18,
  parameter int unsigned ADDR_W     = 23,
  localparam int unsigned TRK_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [SAMPLE_W-1:0]   live_in,
  input  logic                  rec_en,
  input  logic [TRK_W-1:0]      rec_track,
  input  logic                  overdub,
  input  logic [NUM_TRACKS-1:0] play_mask,
  input  logic [LEN_W-1:0]      loop_len,
  input  logic                  clear_pos,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [SAMPLE_W-1:0]   mem_wdata,
  input  logic                  mem_ack,
  input  logic [SAMPLE_W-1:0]   mem_rdata,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  mix_valid,
  output logic [LEN_W-1:0]      pos,
  output logic                  busy,
  output logic                  overrun
);

  // The accumulator holds live plus NUM_TRACKS samples without overflow.
  localparam int unsigned ACC_W = SAMPLE_W + TRK_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'($signed({1'b0, {(SAMPLE_W-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] SAT_LO =
    ACC_W'($signed({1'b1, {(SAMPLE_W-1){1'b0}}}));

  if (ADDR_W < TRK_W + LEN_W) begin : g_addr_w_chk
    $error("multitrack_looper: ADDR_W must be >= TRK_W + LEN_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_NEXT, S_DONE} state_t;

  // Clamp a wide signed value to the signed sample range.
  function automatic logic [SAMPLE_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return SAT_HI[SAMPLE_W-1:0];
    else if (a < SAT_LO) return SAT_LO[SAMPLE_W-1:0];
    else                 return a[SAMPLE_W-1:0];
  endfunction

  // First state for track t: read if it plays or is overdubbed, else write if recorded, else skip.
  function automatic state_t entry_state(input logic [NUM_TRACKS-1:0] mask,
                                         input logic                  re,
                                         input logic [TRK_W-1:0]      rt,
                                         input logic                  od,
                                         input logic [TRK_W-1:0]      t);
    logic is_rec;
    is_rec = re & (rt == t);
    if (mask[t] | (is_rec & od)) return S_RD;
    else if (is_rec)             return S_WR;
    else                         return S_NEXT;
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [TRK_W-1:0]         r_trk, w_trk_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [SAMPLE_W-1:0]      r_old, w_old_nxt;
  logic [SAMPLE_W-1:0]      r_live, w_live_nxt;
  logic                     r_rec_en, w_rec_en_nxt;
  logic [TRK_W-1:0]         r_rec_trk, w_rec_trk_nxt;
  logic                     r_overdub, w_overdub_nxt;
  logic [NUM_TRACKS-1:0]    r_mask, w_mask_nxt;
  logic                     r_clr_pend, w_clr_pend_nxt;
  logic [LEN_W-1:0]         r_pos, w_pos_nxt;
  logic                     r_mem_req, w_mem_req_nxt;
  logic                     r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]        r_mem_addr, w_mem_addr_nxt;
  logic [SAMPLE_W-1:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic [SAMPLE_W-1:0]      r_mix_out, w_mix_out_nxt;
  logic                     r_mix_valid, w_mix_valid_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_overrun, w_overrun_nxt;

  logic [TRK_W-1:0]         w_trk_inc;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [ACC_W-1:0]  w_rd_ext;
  logic signed [ACC_W-1:0]  w_od_sum;
  logic [LEN_W:0]           w_pos_inc;
  logic [LEN_W:0]           w_eff_len;
  logic                     w_is_rec;

  assign w_trk_inc = r_trk + TRK_W'(1);
  assign w_addr    = ADDR_W'({r_trk, r_pos});
  assign w_rd_ext  = ACC_W'($signed(mem_rdata));
  assign w_od_sum  = ACC_W'($signed(r_old)) + ACC_W'($signed(r_live));
  assign w_pos_inc = {1'b0, r_pos} + (LEN_W+1)'(1);
  assign w_eff_len = (loop_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, loop_len};
  assign w_is_rec  = r_rec_en & (r_rec_trk == r_trk);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk       <= '0;
      r_acc       <= '0;
      r_old       <= '0;
      r_live      <= '0;
      r_rec_en    <= 1'b0;
      r_rec_trk   <= '0;
      r_overdub   <= 1'b0;
      r_mask      <= '0;
      r_clr_pend  <= 1'b0;
      r_pos       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_trk       <= w_trk_nxt;
      r_acc       <= w_acc_nxt;
      r_old       <= w_old_nxt;
      r_live      <= w_live_nxt;
      r_rec_en    <= w_rec_en_nxt;
      r_rec_trk   <= w_rec_trk_nxt;
      r_overdub   <= w_overdub_nxt;
      r_mask      <= w_mask_nxt;
      r_clr_pend  <= w_clr_pend_nxt;
      r_pos       <= w_pos_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mix_out   <= w_mix_out_nxt;
      r_mix_valid <= w_mix_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_trk_nxt       = r_trk;
    w_acc_nxt       = r_acc;
    w_old_nxt       = r_old;
    w_live_nxt      = r_live;
    w_rec_en_nxt    = r_rec_en;
    w_rec_trk_nxt   = r_rec_trk;
    w_overdub_nxt   = r_overdub;
    w_mask_nxt      = r_mask;
    w_pos_nxt       = r_pos;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mix_out_nxt   = r_mix_out;
    w_mix_valid_nxt = 1'b0;
    w_busy_nxt      = r_busy;
    // Any tick outside IDLE (DONE included) is dropped and flagged.
    w_overrun_nxt   = r_overrun | (sample_tick & (r_state != S_IDLE));
    w_clr_pend_nxt  = r_clr_pend | (clear_pos & (r_state != S_IDLE));

    case (r_state)
      S_IDLE: begin
        if (clear_pos) w_pos_nxt = '0;
        if (sample_tick) begin
          w_live_nxt     = live_in;
          w_rec_en_nxt   = rec_en;
          w_rec_trk_nxt  = rec_track;
          w_overdub_nxt  = overdub;
          w_mask_nxt     = play_mask;
          w_acc_nxt      = ACC_W'($signed(live_in));
          w_trk_nxt      = '0;
          w_clr_pend_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = entry_state(play_mask, rec_en, rec_track, overdub, TRK_W'(0));
        end
      end
      S_RD: begin
        // req is always low on entry, which guarantees the idle gap between transfers.
        if (!r_mem_req) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = w_addr;
        end else if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_old_nxt     = mem_rdata;
          if (r_mask[r_trk]) w_acc_nxt = r_acc + w_rd_ext;
          w_state_nxt   = w_is_rec ? S_WR : S_NEXT;
        end
      end
      S_WR: begin
        if (!r_mem_req) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = w_addr;
          w_mem_wdata_nxt = r_overdub ? sat_acc(w_od_sum) : r_live;
        end else if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (r_trk == TRK_W'(NUM_TRACKS - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_trk_nxt   = w_trk_inc;
          w_state_nxt = entry_state(r_mask, r_rec_en, r_rec_trk, r_overdub, w_trk_inc);
        end
      end
      S_DONE: begin
        w_mix_out_nxt   = sat_acc(r_acc);
        w_mix_valid_nxt = 1'b1;
        // >= so a loop_len shrunk below pos still wraps.
        if (r_clr_pend | clear_pos)    w_pos_nxt = '0;
        else if (w_pos_inc >= w_eff_len) w_pos_nxt = '0;
        else                           w_pos_nxt = w_pos_inc[LEN_W-1:0];
        w_clr_pend_nxt  = 1'b0;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;
  assign pos       = r_pos;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_multitrack_looper.sv
// Testbench for multitrack_looper: a RAM responder with random ack delay, and a
// frame-level reference model that predicts the transfer list, mix and position.
module tb_multitrack_looper;

  localparam int NT = 4;
  localparam int SW = 16;
  localparam int LW = 4;
  localparam int AW = 8;
  localparam int TW = 2;

  logic          clk;
  logic          rst_n;
  logic          sample_tick;
  logic [SW-1:0] live_in;
  logic          rec_en;
  logic [TW-1:0] rec_track;
  logic          overdub;
  logic [NT-1:0] play_mask;
  logic [LW-1:0] loop_len;
  logic          clear_pos;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic          mem_ack;
  logic [SW-1:0] mem_rdata;
  logic [SW-1:0] mix_out;
  logic          mix_valid;
  logic [LW-1:0] pos;
  logic          busy;
  logic          overrun;

  multitrack_looper #(.NUM_TRACKS(NT), .SAMPLE_W(SW), .LEN_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .live_in(live_in),
    .rec_en(rec_en), .rec_track(rec_track), .overdub(overdub), .play_mask(play_mask),
    .loop_len(loop_len), .clear_pos(clear_pos), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mix_out(mix_out), .mix_valid(mix_valid), .pos(pos), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit we;
    int addr;
    int data;
  } txn_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   ram[0:(1<<AW)-1];
  int   ref_ram[0:(1<<AW)-1];
  txn_t txq[$];
  txn_t expq[$];
  int   ref_pos;
  bit   ref_ovr;
  int   ack_delay = -1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  // RAM responder: random or fixed ack delay, occasional stray acks while idle.
  initial begin
    int cnt;
    bit pend;
    bit real_ack;
    logic [AW+SW:0] snap;
    mem_ack = 1'b0; mem_rdata = '0; pend = 0; real_ack = 0; cnt = 0; snap = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_ack = 1'b0; pend = 0; real_ack = 0;
      end else begin
        if (mem_ack && real_ack) begin
          chk("req_gap", mem_req, 0);
          pend = 0;
        end
        mem_ack = 1'b0;
        real_ack = 0;
        if (mem_req) begin
          if (!pend) begin
            pend = 1;
            snap = {mem_we, mem_addr, mem_wdata};
            cnt  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          end else begin
            chk("req_stable", {mem_we, mem_addr, mem_wdata}, snap);
          end
          if (cnt == 0) begin
            mem_ack = 1'b1; real_ack = 1;
            if (mem_we) begin
              ram[mem_addr] = s16(mem_wdata);
              txq.push_back('{1'b1, int'(mem_addr), s16(mem_wdata)});
            end else begin
              mem_rdata = SW'(ram[mem_addr]);
              txq.push_back('{1'b0, int'(mem_addr), ram[mem_addr]});
            end
          end else begin
            cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = SW'($urandom);
        end
      end
    end
  end

  task automatic idle_clear();
    clear_pos = 1'b1;
    @(posedge clk); #1;
    clear_pos = 1'b0;
    ref_pos = 0;
    chk("clr_idle", pos, 0);
  endtask

  // One frame: predict transfers, mix and next pos from the behavioural rules, then compare.
  task automatic run_frame(input int live, input bit re, input int rt, input bit od,
                           input int mask, input int ll, input bit clr,
                           input int inj_at, input bit inj_tick, input bit inj_clr,
                           input bit chk_lat);
    int acc, old, a, n, eff, wd, lim;
    bit pend, seen, isrec;
    txq.delete(); expq.delete();
    loop_len = LW'(ll); live_in = SW'(live); rec_en = re; rec_track = TW'(rt);
    overdub = od; play_mask = NT'(mask); clear_pos = clr; sample_tick = 1'b1;
    if (clr) ref_pos = 0;
    acc = live; old = 0;
    for (int k = 0; k < NT; k++) begin
      isrec = re && (rt == k);
      a = k * (1 << LW) + ref_pos;
      if (mask[k] || (isrec && od)) begin
        old = ref_ram[a];
        expq.push_back('{1'b0, a, old});
        if (mask[k]) acc += old;
      end
      if (isrec) begin
        wd = od ? sat16(old + live) : live;
        expq.push_back('{1'b1, a, wd});
        ref_ram[a] = wd;
      end
    end
    @(posedge clk); #1;
    sample_tick = 1'b0; clear_pos = 1'b0;
    // Scramble snapshot inputs: the running frame must not see them.
    live_in = SW'($urandom); rec_en = 1'($urandom); rec_track = TW'($urandom);
    overdub = 1'($urandom); play_mask = NT'($urandom);
    pend = 0; seen = 0; n = 1;
    while (n < 300) begin
      if (mix_valid) begin seen = 1; break; end
      if (n == inj_at && busy) begin
        sample_tick = inj_tick; clear_pos = inj_clr;
        if (inj_tick) ref_ovr = 1;
        if (inj_clr) pend = 1;
      end
      @(posedge clk); #1;
      sample_tick = 1'b0; clear_pos = 1'b0;
      n++;
    end
    chk("frame_done", seen, 1);
    eff = (ll == 0) ? (1 << LW) : ll;
    ref_pos = pend ? 0 : ((ref_pos + 1 >= eff) ? 0 : ref_pos + 1);
    chk("mix_out", s16(mix_out), sat16(acc));
    chk("pos", pos, ref_pos);
    chk("busy_end", busy, 0);
    chk("overrun", overrun, ref_ovr);
    chk("txn_count", txq.size(), expq.size());
    lim = (txq.size() < expq.size()) ? txq.size() : expq.size();
    for (int i = 0; i < lim; i++) begin
      chk("txn_we", txq[i].we, expq[i].we);
      chk("txn_addr", txq[i].addr, expq[i].addr);
      if (expq[i].we) chk("txn_wdata", txq[i].data, expq[i].data);
    end
    if (chk_lat) chk("latency", n + 1, 7);
    @(posedge clk); #1;
    chk("mv_pulse", mix_valid, 0);
  endtask

  initial begin
    int exp_seq[9];
    int cnt_mv, inj, w;
    exp_seq = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
    rst_n = 1'b0;
    sample_tick = 1'b0; live_in = '0; rec_en = 1'b0; rec_track = '0; overdub = 1'b0;
    play_mask = '0; loop_len = '0; clear_pos = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = int'($urandom_range(0, 65535)) - 32768;
      ref_ram[i] = ram[i];
    end
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_mix", mix_out, 0);
    chk("rst_mv", mix_valid, 0);
    chk("rst_pos", pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ref_pos = 0; ref_ovr = 0;

    // Empty frame: no RAM traffic, live passes through.
    run_frame(32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_mix", s16(mix_out), 32'h1234);
    chk("t1_pos", pos, 1);
    chk("t1_noreq", txq.size(), 0);

    // Replace-record on track 2 at pos 7 with a slow ack.
    idle_clear();
    for (int i = 0; i < 7; i++) run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ack_delay = 3;
    run_frame(-5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_count", txq.size(), 1);
    chk("t2_we", txq[0].we, 1);
    chk("t2_addr", txq[0].addr, 2 * 16 + 7);
    chk("t2_wdata", txq[0].data & 32'hFFFF, 32'hFFFB);
    ack_delay = -1;

    // Overdub with positive saturation.
    idle_clear();
    ram[16] = 32'h7000; ref_ram[16] = 32'h7000;
    run_frame(32'h2000, 1, 1, 1, 4'b0010, 0, 0, 0, 0, 0, 0);
    chk("t3_mix", s16(mix_out), 32767);

    // Loop length 3, then full-range wrap, then shrinking below pos.
    idle_clear();
    for (int i = 0; i < 9; i++) begin
      run_frame(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
      chk("t4_seq", pos, exp_seq[i]);
    end
    idle_clear();
    for (int i = 0; i < 16; i++) run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_wrap", pos, 0);
    for (int i = 0; i < 10; i++) run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    chk("t4_shrink", pos, 0);

    // Tick and clear_pos while busy.
    run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ack_delay = 6;
    run_frame(100, 0, 0, 0, 4'hF, 0, 0, 3, 1, 1, 0);
    chk("t5_ovr", overrun, 1);
    chk("t5_pos", pos, 0);
    cnt_mv = 0;
    repeat (30) begin @(posedge clk); #1; cnt_mv += int'(mix_valid); end
    chk("t5_single", cnt_mv, 0);

    // Reset during a write transfer.
    ack_delay = 10;
    run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    live_in = SW'(77); rec_en = 1'b1; rec_track = '0; overdub = 1'b0; play_mask = '0;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    w = 0;
    while (!(mem_req && mem_we) && w < 20) begin @(posedge clk); #1; w++; end
    chk("t6_wr_seen", mem_req && mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", mem_req, 0);
    chk("t6_mix", mix_out, 0);
    chk("t6_pos", pos, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovr", overrun, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ref_pos = 0; ref_ovr = 0; ack_delay = -1;
    run_frame(1000, 1, 3, 1, 4'b1001, 0, 0, 0, 0, 0, 0);

    // Random frames, occasionally disturbed mid-frame.
    for (int f = 0; f < 60; f++) begin
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
      run_frame(int'($urandom_range(0, 65535)) - 32768, 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 9) == 0), inj, 1'($urandom), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
